uart_cmd_parse: RTL and testbench

UART_CMD_PARSE -- requirements
Module: uart_cmd_parse

---
 rtl/uart_cmd_parse_pkg.sv | 31 +++
 rtl/uart_cmd_parse_hex_dec.sv | 22 ++
 rtl/uart_cmd_parse.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_parse.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parse_pkg.sv
// Shared definitions for the UART command parser: FSM states, ASCII constants,
// error codes and small character-class helpers.
package uart_cmd_parse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ARG  = 2'd2
  } state_t;

  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [1:0] ERR_BADCHAR  = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_FRAME    = 2'd2;
  localparam logic [1:0] ERR_NOCMD    = 2'd3;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  // Only meaningful for letters: clearing bit 5 folds a-z onto A-Z.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return {c[7:6], 1'b0, c[4:0]};
  endfunction

endpackage

// File: rtl/uart_cmd_parse_hex_dec.sv
// Combinational ASCII hex digit decoder: flags 0-9/A-F/a-f and returns the nibble value.
module ascii_hex_dec (
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if ((ascii >= 8'h30) && (ascii <= 8'h39)) begin
      is_hex = 1'b1;
      nibble = ascii[3:0];
    end else if (((ascii >= 8'h41) && (ascii <= 8'h46)) ||
                 ((ascii >= 8'h61) && (ascii <= 8'h66))) begin
      // 'A'/'a' carry low nibble 1, so +9 lands on 10.
      is_hex = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parse.sv
// Parses "*<letter><0..4 hex digits>CR" commands from a UART receiver and
// emits a one-clock cmd_valid or cmd_err pulse per command.
module uart_cmd_parse
  import uart_cmd_parse_pkg::*;
(
  input  logic        clk_rx,
  input  logic        rst_clk_rx,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  input  logic        frm_err,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic [2:0]  cmd_nargs,
  output logic        cmd_err,
  output logic [1:0]  err_code
);

  state_t      state, state_next;
  logic        rdy_q, frm_q;
  logic        accept, frm_event;
  logic        is_hex;
  logic [3:0]  nibble;
  logic [7:0]  code_reg;
  logic [15:0] arg_reg;
  logic [2:0]  count;
  logic        valid_set, err_set, code_load, arg_shift;
  logic [1:0]  err_sel;

  ascii_hex_dec u_hex (
    .ascii  (rx_data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  // Edge detectors reset high so a level already present at release is not an event.
  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      rdy_q <= 1'b1;
      frm_q <= 1'b1;
    end else begin
      rdy_q <= rx_data_rdy;
      frm_q <= frm_err;
    end
  end

  assign accept    = rx_data_rdy & ~rdy_q;
  assign frm_event = frm_err & ~frm_q;

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) state <= ST_IDLE;
    else            state <= state_next;
  end

  // A framing event outranks a character arriving in the same cycle.
  always_comb begin
    state_next = state;
    if (frm_event) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE: if (rx_data == CH_STAR) state_next = ST_CMD;
        ST_CMD: begin
          if (is_letter(rx_data))       state_next = ST_ARG;
          else if (rx_data != CH_STAR)  state_next = ST_IDLE;
        end
        ST_ARG: begin
          if (is_hex) begin
            if (count == MAX_DIGITS)    state_next = ST_IDLE;
          end else if (rx_data == CH_STAR) begin
            state_next = ST_CMD;
          end else if (rx_data != CH_SPACE) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    valid_set = 1'b0;
    err_set   = 1'b0;
    err_sel   = ERR_BADCHAR;
    code_load = 1'b0;
    arg_shift = 1'b0;
    if (frm_event) begin
      if (state != ST_IDLE) begin
        err_set = 1'b1;
        err_sel = ERR_FRAME;
      end
    end else if (accept) begin
      case (state)
        ST_CMD: begin
          if (is_letter(rx_data)) begin
            code_load = 1'b1;
          end else if (rx_data == CH_CR) begin
            err_set = 1'b1;
            err_sel = ERR_NOCMD;
          end else if (rx_data != CH_STAR) begin
            err_set = 1'b1;
          end
        end
        ST_ARG: begin
          if (is_hex) begin
            if (count == MAX_DIGITS) begin
              err_set = 1'b1;
              err_sel = ERR_OVERFLOW;
            end else begin
              arg_shift = 1'b1;
            end
          end else if (rx_data == CH_CR) begin
            valid_set = 1'b1;
          end else if ((rx_data != CH_STAR) && (rx_data != CH_SPACE)) begin
            err_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      err_code  <= 2'd0;
      cmd_code  <= 8'd0;
      cmd_arg   <= 16'd0;
      cmd_nargs <= 3'd0;
      code_reg  <= 8'd0;
      arg_reg   <= 16'd0;
      count     <= 3'd0;
    end else begin
      cmd_valid <= valid_set;
      cmd_err   <= err_set;
      if (err_set) err_code <= err_sel;
      if (code_load) begin
        code_reg <= to_upper(rx_data);
        arg_reg  <= 16'd0;
        count    <= 3'd0;
      end
      if (arg_shift) begin
        arg_reg <= {arg_reg[11:0], nibble};
        count   <= count + 3'd1;
      end
      if (valid_set) begin
        cmd_code  <= code_reg;
        cmd_arg   <= arg_reg;
        cmd_nargs <= count;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parse.sv
// Self-checking bench for uart_cmd_parse: a command-level reference model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_uart_cmd_parse;

  logic        clk_rx = 1'b0;
  logic        rst_clk_rx;
  logic [7:0]  rx_data;
  logic        rx_data_rdy;
  logic        frm_err;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_arg;
  logic [2:0]  cmd_nargs;
  logic        cmd_err;
  logic [1:0]  err_code;

  always #5 clk_rx = ~clk_rx;

  uart_cmd_parse dut (
    .clk_rx      (clk_rx),
    .rst_clk_rx  (rst_clk_rx),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .frm_err     (frm_err),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_arg     (cmd_arg),
    .cmd_nargs   (cmd_nargs),
    .cmd_err     (cmd_err),
    .err_code    (err_code)
  );

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int err_seen = 0;
  bit check_en = 1'b0;

  // Reference model: tracks the command being collected as text-level facts.
  bit          m_started;
  bit          m_has_letter;
  logic [7:0]  m_letter;
  int          m_ndig;
  logic [15:0] m_val;

  logic        exp_valid, exp_err;
  logic [1:0]  exp_err_code;
  logic [7:0]  exp_code;
  logic [15:0] exp_arg;
  logic [2:0]  exp_nargs;

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int hex_value(input logic [7:0] c);
    string digits;
    logic [7:0] lc;
    digits = "0123456789abcdef";
    lc = ((c >= "A") && (c <= "Z")) ? c + 8'd32 : c;
    for (int i = 0; i < 16; i++) if (digits[i] == lc) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_started = 0; m_has_letter = 0; m_letter = 0; m_ndig = 0; m_val = 0;
    exp_valid = 0; exp_err = 0; exp_err_code = 0;
    exp_code = 0; exp_arg = 0; exp_nargs = 0;
  endtask

  task automatic model_error(input logic [1:0] code);
    exp_err = 1'b1;
    exp_err_code = code;
    m_started = 0;
  endtask

  task automatic model_char(input logic [7:0] c);
    int h;
    h = hex_value(c);
    if (!m_started) begin
      if (c == "*") begin m_started = 1; m_has_letter = 0; end
    end else if (!m_has_letter) begin
      if (((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z"))) begin
        m_has_letter = 1;
        m_letter = ((c >= "a") && (c <= "z")) ? c - 8'd32 : c;
        m_val = 0;
        m_ndig = 0;
      end else if (c == 8'h0D) model_error(2'd3);
      else if (c != "*") model_error(2'd0);
    end else begin
      if (h >= 0) begin
        if (m_ndig == 4) model_error(2'd1);
        else begin
          m_val = m_val * 16 + 16'(h);
          m_ndig++;
        end
      end else if (c == 8'h0D) begin
        exp_valid = 1'b1;
        exp_code = m_letter;
        exp_arg = m_val;
        exp_nargs = 3'(m_ndig);
        m_started = 0;
      end else if (c == "*") m_has_letter = 0;
      else if (c != " ") model_error(2'd0);
    end
  endtask

  task automatic model_frame();
    if (m_started) model_error(2'd2);
  endtask

  always @(negedge clk_rx) begin
    if (check_en) begin
      check_output("cmd_valid", 16'(cmd_valid), 16'(exp_valid));
      check_output("cmd_err",   16'(cmd_err),   16'(exp_err));
      check_output("err_code",  16'(err_code),  16'(exp_err_code));
      check_output("cmd_code",  16'(cmd_code),  16'(exp_code));
      check_output("cmd_arg",   cmd_arg,        exp_arg);
      check_output("cmd_nargs", 16'(cmd_nargs), 16'(exp_nargs));
      if (cmd_valid) valid_seen++;
      if (cmd_err)   err_seen++;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic [7:0] c, input int hold);
    @(negedge clk_rx); #1;
    rx_data = c;
    rx_data_rdy = 1'b1;
    @(posedge clk_rx);
    model_char(c);
    repeat (hold - 1) @(posedge clk_rx);
    #1 rx_data_rdy = 1'b0;
    repeat (2) @(posedge clk_rx);
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) apply_stimulus(s[i], hold);
  endtask

  task automatic frame_pulse(input bit with_char, input logic [7:0] c);
    @(negedge clk_rx); #1;
    frm_err = 1'b1;
    if (with_char) begin
      rx_data = c;
      rx_data_rdy = 1'b1;
    end
    @(posedge clk_rx);
    model_frame();
    repeat (3) @(posedge clk_rx);
    #1;
    frm_err = 1'b0;
    rx_data_rdy = 1'b0;
    repeat (2) @(posedge clk_rx);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_rx);
    #2;
  endtask

  int v0, e0;

  initial begin
    rst_clk_rx = 1'b1;
    rx_data = 8'h00;
    rx_data_rdy = 1'b0;
    frm_err = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_rx);
    #2;
    check_output("reset_valid", 16'(cmd_valid), 16'd0);
    check_output("reset_err",   16'(cmd_err),   16'd0);
    check_output("reset_code",  16'(cmd_code),  16'd0);
    check_output("reset_arg",   cmd_arg,        16'd0);
    check_output("reset_nargs", 16'(cmd_nargs), 16'd0);
    check_output("reset_errc",  16'(err_code),  16'd0);
    check_en = 1'b1;
    @(negedge clk_rx); #1 rst_clk_rx = 1'b0;
    repeat (3) @(posedge clk_rx);

    // Full four-digit command, long hold per character
    v0 = valid_seen; e0 = err_seen;
    send_str("*W12aF", 16); apply_stimulus(8'h0D, 16); settle();
    check_output("w12af_count", 16'(valid_seen - v0), 16'd1);
    check_output("w12af_errs",  16'(err_seen - e0),   16'd0);
    check_output("w12af_code",  16'(cmd_code),  16'h57);
    check_output("w12af_arg",   cmd_arg,        16'h12AF);
    check_output("w12af_nargs", 16'(cmd_nargs), 16'd4);

    // No-argument command, then missing letter
    send_str("*r", 4); apply_stimulus(8'h0D, 4); settle();
    check_output("r_code",  16'(cmd_code),  16'h52);
    check_output("r_arg",   cmd_arg,        16'h0000);
    check_output("r_nargs", 16'(cmd_nargs), 16'd0);
    v0 = valid_seen; e0 = err_seen;
    send_str("*", 4); apply_stimulus(8'h0D, 4); settle();
    check_output("nocmd_errs",  16'(err_seen - e0),   16'd1);
    check_output("nocmd_valid", 16'(valid_seen - v0), 16'd0);
    check_output("nocmd_code",  16'(err_code),        16'd3);
    check_output("nocmd_hold",  16'(cmd_code),        16'h52);

    // Fifth digit overflows; next command is clean
    e0 = err_seen;
    send_str("*W12345", 3); settle();
    check_output("ovf_errs", 16'(err_seen - e0), 16'd1);
    check_output("ovf_code", 16'(err_code),      16'd1);
    send_str("*A1", 3); apply_stimulus(8'h0D, 3); settle();
    check_output("a1_code", 16'(cmd_code), 16'h41);
    check_output("a1_arg",  cmd_arg,       16'h0001);

    // Bad character, then restart-with-star and ignored space
    send_str("*W1G", 5); settle();
    check_output("badchar_code", 16'(err_code), 16'd0);
    v0 = valid_seen; e0 = err_seen;
    send_str("*W1*X 3", 5); apply_stimulus(8'h0D, 5); settle();
    check_output("x3_count", 16'(valid_seen - v0), 16'd1);
    check_output("x3_errs",  16'(err_seen - e0),   16'd0);
    check_output("x3_code",  16'(cmd_code),  16'h58);
    check_output("x3_arg",   cmd_arg,        16'h0003);
    check_output("x3_nargs", 16'(cmd_nargs), 16'd1);

    // Framing error mid-command returns to idle; idle ignores frame errors
    v0 = valid_seen; e0 = err_seen;
    send_str("*W1", 4); frame_pulse(1'b0, 8'h00);
    send_str("1", 4); apply_stimulus(8'h0D, 4); settle();
    check_output("frame_errs",  16'(err_seen - e0),   16'd1);
    check_output("frame_code",  16'(err_code),        16'd2);
    check_output("frame_valid", 16'(valid_seen - v0), 16'd0);
    e0 = err_seen;
    frame_pulse(1'b0, 8'h00); settle();
    check_output("idle_frame_errs", 16'(err_seen - e0), 16'd0);

    // Frame error coincident with a character edge drops the character
    send_str("*B2", 4); apply_stimulus(8'h0D, 4);
    v0 = valid_seen; e0 = err_seen;
    send_str("*W", 4); frame_pulse(1'b1, "3"); apply_stimulus(8'h0D, 4); settle();
    check_output("coinc_errs",  16'(err_seen - e0),   16'd1);
    check_output("coinc_valid", 16'(valid_seen - v0), 16'd0);
    check_output("coinc_code",  16'(err_code),        16'd2);
    check_output("coinc_arg",   cmd_arg,              16'h0002);

    // Reset mid-command with rdy held high across release
    v0 = valid_seen; e0 = err_seen;
    send_str("*W12", 4);
    @(negedge clk_rx); #1;
    rst_clk_rx = 1'b1;
    model_reset();
    rx_data = "*";
    rx_data_rdy = 1'b1;
    repeat (3) @(negedge clk_rx);
    #1 rst_clk_rx = 1'b0;
    repeat (6) @(posedge clk_rx);
    #1 rx_data_rdy = 1'b0;
    repeat (2) @(posedge clk_rx);
    send_str("B", 4); apply_stimulus(8'h0D, 4); settle();
    check_output("rst_valid", 16'(valid_seen - v0), 16'd0);
    check_output("rst_errs",  16'(err_seen - e0),   16'd0);
    check_output("rst_arg",   cmd_arg,              16'h0000);
    send_str("*B", 4); apply_stimulus(8'h0D, 4); settle();
    check_output("b_count", 16'(valid_seen - v0), 16'd1);
    check_output("b_code",  16'(cmd_code),        16'h42);
    check_output("b_nargs", 16'(cmd_nargs),       16'd0);

    repeat (3) @(negedge clk_rx);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
